// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to a variable-latency
// instruction memory and buffers tagged responses in a small FIFO; redirects flush and squash.
module fetch_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [XLEN-1:0]            instr_pc,
    output logic [XLEN-1:0]            instr_pcplus4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DepthCap = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic            req_fire;
    logic            push;
    logic            pop;
    logic [CW:0]     credits_used;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Buffered plus in-flight fetches never exceed DEPTH, so a response always has a free slot.
    always_comb begin
        credits_used   = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req_valid = !rst && !redirect_valid && (credits_used < DepthCap);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        instr_valid    = !rst && !redirect_valid && (count_q != '0);
        pop            = instr_valid && instr_ready;
        push           = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
        instr          = instr_mem[head_q];
        instr_pc       = pc_mem[head_q];
        instr_pcplus4  = pc_mem[head_q] + XLEN'(4);
        occupancy      = count_q;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                tail_d   = tail_q + PW'(1);
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rsp_data;
            pc_mem[tail_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a fixed-latency memory model, a driver issuing stimulus and
// queueing expected deliveries, and a monitor that scores every instruction decode consumes.
module tb_fetch_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   instr_pc;
    logic [XLEN-1:0]   instr_pcplus4;
    logic [2:0]        occupancy;

    int                n_cmp   = 0;
    int                n_bad   = 0;
    int                n_deliv = 0;
    int                mem_lat = 1;
    logic [31:0]       exp_q[$];

    always #5 clk = ~clk;

    fetch_buffer #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4),
        .occupancy     (occupancy)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A3C_0F13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_deliv(input int target);
        for (int i = 0; i < 300 && n_deliv < target; i++) tick();
        check("deliver_count", 32'(n_deliv), 32'(target));
    endtask

    task automatic wait_occ(input int occ);
        for (int i = 0; i < 100 && 32'(occupancy) != 32'(occ); i++) tick();
        check("occ_reach", 32'(occupancy), 32'(occ));
    endtask

    task automatic do_reset(input int lat);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        mem_lat        = lat;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_instr_valid2", 32'(instr_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_addr", imem_req_addr, 32'h0000_0000);
    endtask

    // Fixed-latency in-order instruction memory, reset on the same rst as the DUT.
    initial begin
        logic [31:0] pend_addr[$];
        int          pend_due[$];
        int          cyc;
        logic        fire;
        logic        rst_s;
        logic [31:0] a;
        cyc            = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            fire  = imem_req_valid && imem_req_ready;
            a     = imem_req_addr;
            rst_s = rst;
            #1;
            if (rst_s) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (fire) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc + mem_lat);
            end
            cyc++;
            imem_rsp_valid = 1'b0;
            if (!rst_s && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    // Monitor: scores each pop against the head of the expected queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_deliver: got pc %h expected none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pc", instr_pc, e);
                    check("mon_instr", instr, instr_of(e));
                    check("mon_pcplus4", instr_pcplus4, e + 32'd4);
                end
                n_deliv++;
            end
        end
    end

    initial begin
        int base;
        int hs;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Streaming from reset with a 1-cycle memory.
        do_reset(1);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        tick();
        check("seq_addr1", imem_req_addr, 32'h4);
        tick();
        check("seq_addr2", imem_req_addr, 32'h8);
        check("lat_instr_valid", 32'(instr_valid), 32'd1);
        check("lat_instr_pc", instr_pc, 32'h0);
        check("lat_pcplus4", instr_pcplus4, 32'h4);
        wait_deliv(6);

        // Back-pressure from reset.
        instr_ready = 1'b0;
        do_reset(1);
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid && imem_req_ready) hs++;
            tick();
        end
        check("stall_handshakes", 32'(hs), 32'd4);
        check("stall_occ", 32'(occupancy), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_addr", imem_req_addr, 32'h10);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        base        = n_deliv;
        instr_ready = 1'b1;
        tick();
        check("resume_valid", 32'(imem_req_valid), 32'd1);
        check("resume_addr", imem_req_addr, 32'h10);
        wait_deliv(base + 4);

        // Redirect with a nearly full FIFO, a response arriving and a pop requested.
        instr_ready = 1'b0;
        wait_occ(3);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        instr_ready    = 1'b1;
        #1;
        check("redir_no_issue", 32'(imem_req_valid), 32'd0);
        check("redir_no_out", 32'(instr_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_instr_valid", 32'(instr_valid), 32'd0);
        check("flush_req_valid", 32'(imem_req_valid), 32'd1);
        check("flush_addr", imem_req_addr, 32'h100);
        tick();
        check("flush_wait_data", 32'(instr_valid), 32'd0);
        wait_deliv(base + 6);

        // Misaligned redirect target.
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("align_valid", 32'(imem_req_valid), 32'd1);
        check("align_addr", imem_req_addr, 32'h200);
        wait_deliv(base + 8);

        // Reset mid-stream with three buffered entries.
        instr_ready = 1'b0;
        wait_occ(3);
        instr_ready = 1'b1;
        do_reset(3);

        // 3-cycle memory: redirect squashes two in-flight fetches.
        base = n_deliv;
        tick();
        tick();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("inflight_noreq", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("inflight_addr", imem_req_addr, 32'h100);
        check("inflight_valid", 32'(imem_req_valid), 32'd1);
        wait_deliv(base + 2);

        // Address wrap plus request held under imem back-pressure.
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(imem_req_valid), 32'd1);
            check("hold_addr", imem_req_addr, 32'hFFFF_FFFC);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        check("wrap_addr", imem_req_addr, 32'h0000_0000);
        wait_deliv(base + 5);

        instr_ready = 1'b0;
        repeat (5) tick();
        check("exp_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
